core_mem_bridge: RTL and testbench
==================================

Name: core_mem_bridge

Overview:
- Memory-side responder for the core's word-transfer interface (`mem_start`, `mem_write`, `mem_addr`, `mem_data_wr`, `mem_ready`, `mem_data_rd`).
- Takes each single-word request from core control and turns it into one Avalon-MM master transaction (read or write). Completion is returned as a one-cycle `mem_ready` pulse.
- Sits between core control and the system interconnect. One transaction in flight at a time; no buffering beyond the current request.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles from request acceptance to forced completion. Used only with CORE_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_start  in  1  one-cycle request pulse from core.
- mem_write  in  1  1 = write, 0 = read; sampled with mem_start.
- mem_addr  in  30  word address; sampled with mem_start.
- mem_data_wr  in  32  write data; sampled with mem_start.
- mem_ready  out  1  one-cycle completion pulse.
- mem_data_rd  out  32  read data; valid in the mem_ready cycle and held until the next read completes.
- mem_fault  out  1  valid with mem_ready; 1 = transaction timed out.
- avl_address  out  32  byte address = {mem_addr, 2'b00}.
- avl_read  out  1  Avalon read request.
- avl_write  out  1  Avalon write request.
- avl_writedata  out  32  Avalon write data.
- avl_byteenable  out  4  constant 4'b1111.
- avl_waitrequest  in  1  Avalon stall.
- avl_readdata  in  32  Avalon read data.
- avl_readdatavalid  in  1  Avalon read data strobe.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - avl_read, avl_write, mem_ready, mem_fault = 0; mem_data_rd=0; avl_address=0; avl_writedata=0.
  - Outstanding bus requests are dropped immediately.
  - Counter cleared.
- All outputs are registered.
- States: IDLE, REQUEST, WAIT_DATA.
- IDLE:
  - If mem_start=1: latch addr, data and direction into avl_address, avl_writedata and the direction flag.
  - Assert avl_write or avl_read the next cycle; go to REQUEST.
  - mem_start is ignored in REQUEST and WAIT_DATA; core control never issues one there.
- REQUEST:
  - Hold avl_read/avl_write, address and data stable while avl_waitrequest=1.
  - On a cycle with avl_waitrequest=0, the request is accepted:
    - Deassert avl_read/avl_write the next cycle.
    - Write: pulse mem_ready the next cycle and go to IDLE.
    - Read: go to WAIT_DATA.
  - If avl_readdatavalid=1 in the acceptance cycle, treat it as WAIT_DATA completion (skip WAIT_DATA).
- WAIT_DATA:
  - On avl_readdatavalid=1: mem_data_rd <= avl_readdata; pulse mem_ready the next cycle; go to IDLE.
- Latency, mem_start sampled at edge T:
  - Bus request is high during cycle T+1.
  - Minimum write: mem_ready high in T+2.
  - Minimum read (readdatavalid in the acceptance cycle): mem_ready high in T+2.
  - Each waitrequest cycle or readdatavalid delay cycle adds 1.
- Back-to-back: mem_start in the cycle immediately after mem_ready is accepted (IDLE reached on the same edge mem_ready rises).
- mem_ready is never high for two consecutive cycles.
- mem_fault=0 whenever CORE_MEM_TIMEOUT_EN is undefined.
- avl_readdatavalid in IDLE (stale response) is dropped: no mem_ready, mem_data_rd unchanged.

Optional Feature:
- CORE_MEM_TIMEOUT_EN defined:
  - Counter clears on acceptance of mem_start and increments each cycle in REQUEST/WAIT_DATA.
  - When the count reaches TIMEOUT_CYCLES-1 with no completion:
    - Deassert avl_read/avl_write.
    - Pulse mem_ready with mem_fault=1; mem_data_rd unchanged.
    - Go to IDLE.
  - Normal completion in the same cycle as the timeout wins (mem_fault=0).
- Undefined: no counter; the bridge waits indefinitely; mem_fault is tied to 0.

Test Plan:
- Write, waitrequest=0: mem_start with mem_write=1, mem_addr=30'h0000_0010, data 32'hDEADBEEF -> avl_write high 1 cycle, avl_address=32'h40, writedata=DEADBEEF, byteenable=4'hF, mem_ready pulse at T+2.
- Read with 3 waitrequest cycles and readdatavalid 2 cycles after accept with 32'h12345678 -> avl_read held 4 cycles with stable address; mem_ready one cycle after readdatavalid; mem_data_rd=12345678 and held through a following write.
- Back-to-back: second mem_start in the cycle after mem_ready -> second bus request issued the next cycle; no lost or duplicated mem_ready.
- rst_n low while avl_read=1 in REQUEST -> avl_read drops immediately (async); after release, a readdatavalid arriving in IDLE produces no mem_ready.
- CORE_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck high -> avl_read drops and mem_ready=1 with mem_fault=1 eight cycles after acceptance; the next read completes normally with mem_fault=0.
- mem_start asserted during WAIT_DATA -> ignored; only one bus transaction issued and one mem_ready returned.

Source files
------------

// File: rtl/core_mem_bridge_if.sv
// core_mem_bridge_if: core word-transfer port plus the Avalon-MM master port of the bridge.
// Latency: none, wiring only.
// Backpressure: carried by avl_waitrequest; the core side waits for mem_ready.
interface core_mem_bridge_if;
    // Core control side.
    logic        mem_start;
    logic        mem_write;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_wr;
    logic        mem_ready;
    logic [31:0] mem_data_rd;
    logic        mem_fault;

    // Avalon-MM side.
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;

    // slave: the bridge's view (answers the core, masters the Avalon bus).
    modport slave (
        input  mem_start, mem_write, mem_addr, mem_data_wr,
        output mem_ready, mem_data_rd, mem_fault,
        output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid
    );

    // master: the surroundings' view (core control issuing requests, interconnect responding).
    modport master (
        output mem_start, mem_write, mem_addr, mem_data_wr,
        input  mem_ready, mem_data_rd, mem_fault,
        input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        output avl_waitrequest, avl_readdata, avl_readdatavalid
    );
endinterface

// File: rtl/core_mem_bridge.sv
// core_mem_bridge: one Avalon-MM read/write per core request; optional timeout via CORE_MEM_TIMEOUT_EN.
// Latency: bus request the cycle after mem_start; mem_ready at the earliest two cycles after mem_start.
// Backpressure: request held stable through avl_waitrequest; one transaction in flight, no buffering.
module core_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    core_mem_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        avl_read_q, avl_read_d;
    logic        avl_write_q, avl_write_d;
    logic [31:0] avl_address_q, avl_address_d;
    logic [31:0] avl_writedata_q, avl_writedata_d;
    logic        write_q, write_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_data_rd_q, mem_data_rd_d;

    logic accept;
    logic wr_done;
    logic rd_done;
    logic done;
    logic timeout_hit;

    // Completion events; read data arriving in the accept cycle finishes the read right away.
    always_comb begin
        accept  = (state_q == REQUEST) && !bus.avl_waitrequest;
        wr_done = accept && write_q;
        rd_done = ((accept && !write_q) || (state_q == WAIT_DATA)) && bus.avl_readdatavalid;
        done    = wr_done || rd_done;
    end

`ifdef CORE_MEM_TIMEOUT_EN
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_fault_q, mem_fault_d;

    // Timeout only fires when nothing legitimately completes in the same cycle.
    always_comb begin
        timeout_hit = (state_q != IDLE) && (cnt_q == CNT_LAST) && !done;
    end

    // Counter restarts on each accepted request and runs while a transaction is open.
    always_comb begin
        cnt_d       = cnt_q;
        mem_fault_d = timeout_hit;
        if (state_q == IDLE) begin
            if (bus.mem_start) begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter and fault flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign bus.mem_fault = mem_fault_q;
`else
    // Without the timeout the bridge waits as long as the bus takes.
    assign timeout_hit   = 1'b0;
    assign bus.mem_fault = 1'b0;
`endif

    // FSM state register; reset drops any open bus transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; mem_start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_start) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (done || timeout_hit) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (done || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: latch the request, drop it on acceptance or timeout, capture read data.
    always_comb begin
        avl_read_d      = avl_read_q;
        avl_write_d     = avl_write_q;
        avl_address_d   = avl_address_q;
        avl_writedata_d = avl_writedata_q;
        write_d         = write_q;
        mem_data_rd_d   = mem_data_rd_q;
        mem_ready_d     = done || timeout_hit;

        if ((state_q == IDLE) && bus.mem_start) begin
            avl_address_d   = {bus.mem_addr, 2'b00};
            avl_writedata_d = bus.mem_data_wr;
            write_d         = bus.mem_write;
            avl_read_d      = !bus.mem_write;
            avl_write_d     = bus.mem_write;
        end

        if (accept || timeout_hit) begin
            avl_read_d  = 1'b0;
            avl_write_d = 1'b0;
        end

        if (rd_done) begin
            mem_data_rd_d = bus.avl_readdata;
        end
    end

    // Output and request registers; every output of the bridge comes from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avl_read_q      <= 1'b0;
            avl_write_q     <= 1'b0;
            avl_address_q   <= '0;
            avl_writedata_q <= '0;
            write_q         <= 1'b0;
            mem_ready_q     <= 1'b0;
            mem_data_rd_q   <= '0;
        end else begin
            avl_read_q      <= avl_read_d;
            avl_write_q     <= avl_write_d;
            avl_address_q   <= avl_address_d;
            avl_writedata_q <= avl_writedata_d;
            write_q         <= write_d;
            mem_ready_q     <= mem_ready_d;
            mem_data_rd_q   <= mem_data_rd_d;
        end
    end

    assign bus.avl_read       = avl_read_q;
    assign bus.avl_write      = avl_write_q;
    assign bus.avl_address    = avl_address_q;
    assign bus.avl_writedata  = avl_writedata_q;
    assign bus.avl_byteenable = 4'b1111;
    assign bus.mem_ready      = mem_ready_q;
    assign bus.mem_data_rd    = mem_data_rd_q;

endmodule

// File: tb/tb_core_mem_bridge.sv
// tb_core_mem_bridge: scenario tasks driving core requests and an Avalon responder.
// Latency: expectations are cycle counts from the mem_start sampling edge.
// Backpressure: waitrequest/readdatavalid timing is chosen per transaction.
module tb_core_mem_bridge;

`ifdef CORE_MEM_TIMEOUT_EN
    localparam int unsigned TB_TO = 8;
`else
    localparam int unsigned TB_TO = 1024;
`endif
    localparam int TXN_BUDGET = 60;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ready_cnt;
    int   req_cnt;
    int   dbl_cnt;
    logic prev_ready;
    logic prev_req;
    logic [31:0] last_rd;
    exp_t exp_q[$];

    core_mem_bridge_if bif ();

    core_mem_bridge #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background counters of completions, double pulses and bus request starts.
    always @(negedge clk) begin
        if (bif.mem_ready) begin
            ready_cnt <= ready_cnt + 1;
            if (prev_ready) dbl_cnt <= dbl_cnt + 1;
        end
        if ((bif.avl_read || bif.avl_write) && !prev_req) req_cnt <= req_cnt + 1;
        prev_ready <= bif.mem_ready;
        prev_req   <= bif.avl_read || bif.avl_write;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and plays the Avalon slave: n_wait stall cycles, then read data
    // rd_delay cycles after acceptance. Optionally pokes a stray mem_start in cycle poke_cycle.
    task automatic do_txn(input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                          input int n_wait, input int rd_delay, input logic [31:0] rdata,
                          input int poke_cycle, output int lat, output int req_cyc,
                          output bit hold_ok, output logic [31:0] rd_obs, output logic fault_obs);
        logic [31:0] exp_addr;
        exp_addr  = {addr, 2'b00};
        lat       = 0;
        req_cyc   = 0;
        hold_ok   = 1'b1;
        rd_obs    = '0;
        fault_obs = 1'b0;
        bif.mem_start   = 1'b1;
        bif.mem_write   = wr;
        bif.mem_addr    = addr;
        bif.mem_data_wr = wd;
        step();
        bif.mem_start   = 1'b0;
        bif.mem_write   = 1'b0;
        bif.mem_addr    = '0;
        bif.mem_data_wr = '0;
        for (int c = 1; c <= TXN_BUDGET; c++) begin
            if (bif.mem_ready) begin
                lat       = c;
                rd_obs    = bif.mem_data_rd;
                fault_obs = bif.mem_fault;
                break;
            end
            if (bif.avl_read || bif.avl_write) begin
                req_cyc++;
                if (bif.avl_address !== exp_addr || bif.avl_read !== !wr || bif.avl_write !== wr ||
                    bif.avl_byteenable !== 4'hF || (wr && bif.avl_writedata !== wd))
                    hold_ok = 1'b0;
            end
            bif.avl_waitrequest   = (c <= n_wait);
            bif.avl_readdatavalid = !wr && (c == n_wait + 1 + rd_delay);
            bif.avl_readdata      = bif.avl_readdatavalid ? rdata : (32'hBAD0_0000 | 32'(c));
            if (c == poke_cycle) begin
                bif.mem_start   = 1'b1;
                bif.mem_write   = 1'b1;
                bif.mem_addr    = 30'h15;
                bif.mem_data_wr = 32'h5555_AAAA;
            end else begin
                bif.mem_start   = 1'b0;
                bif.mem_write   = 1'b0;
                bif.mem_addr    = '0;
                bif.mem_data_wr = '0;
            end
            step();
        end
        bif.avl_waitrequest   = 1'b0;
        bif.avl_readdatavalid = 1'b0;
        bif.avl_readdata      = '0;
        bif.mem_start         = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bif.avl_read !== 1'b0) begin errors++; $display("FAIL rst_avl_read: got %b want 0", bif.avl_read); end
        checks++; if (bif.avl_write !== 1'b0) begin errors++; $display("FAIL rst_avl_write: got %b want 0", bif.avl_write); end
        checks++; if (bif.mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready: got %b want 0", bif.mem_ready); end
        checks++; if (bif.mem_fault !== 1'b0) begin errors++; $display("FAIL rst_mem_fault: got %b want 0", bif.mem_fault); end
        checks++; if (bif.mem_data_rd !== 32'h0) begin errors++; $display("FAIL rst_mem_data_rd: got %h want 0", bif.mem_data_rd); end
        checks++; if (bif.avl_address !== 32'h0) begin errors++; $display("FAIL rst_avl_address: got %h want 0", bif.avl_address); end
        checks++; if (bif.avl_writedata !== 32'h0) begin errors++; $display("FAIL rst_avl_writedata: got %h want 0", bif.avl_writedata); end
        checks++; if (bif.avl_byteenable !== 4'hF) begin errors++; $display("FAIL rst_byteenable: got %h want f", bif.avl_byteenable); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        int lat, rc; bit ok; logic [31:0] rd; logic flt; exp_t e;
        exp_q.push_back('{data: last_rd, fault: 1'b0, lat: 2});
        do_txn(1'b1, 30'h0000_0010, 32'hDEADBEEF, 0, 0, 32'h0, 0, lat, rc, ok, rd, flt);
        e = exp_q.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (rc != 1) begin errors++; $display("FAIL wr_req_cycles: got %0d want 1", rc); end
        checks++; if (!ok) begin errors++; $display("FAIL wr_bus_fields: got bad addr/data/be want 00000040/deadbeef/f"); end
        checks++; if (rd !== e.data) begin errors++; $display("FAIL wr_data_rd: got %h want %h", rd, e.data); end
        checks++; if (flt !== e.fault) begin errors++; $display("FAIL wr_fault: got %b want %b", flt, e.fault); end
        checks++; if (bif.avl_write !== 1'b0) begin errors++; $display("FAIL wr_req_dropped: got %b want 0", bif.avl_write); end
    endtask

    task automatic test_read_wait();
        int lat, rc; bit ok; logic [31:0] rd; logic flt; exp_t e;
        exp_q.push_back('{data: 32'h12345678, fault: 1'b0, lat: 7});
        do_txn(1'b0, 30'h3FFF_FFFF, 32'h0, 3, 2, 32'h12345678, 0, lat, rc, ok, rd, flt);
        last_rd = 32'h12345678;
        e = exp_q.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (rc != 4) begin errors++; $display("FAIL rd_req_cycles: got %0d want 4", rc); end
        checks++; if (!ok) begin errors++; $display("FAIL rd_bus_fields: got unstable request want addr fffffffc held"); end
        checks++; if (rd !== e.data) begin errors++; $display("FAIL rd_data: got %h want %h", rd, e.data); end
        checks++; if (flt !== e.fault) begin errors++; $display("FAIL rd_fault: got %b want %b", flt, e.fault); end
        // Following write must leave the read data untouched.
        exp_q.push_back('{data: last_rd, fault: 1'b0, lat: 3});
        do_txn(1'b1, 30'h0000_0021, 32'h0BAD_CAFE, 1, 0, 32'h0, 0, lat, rc, ok, rd, flt);
        e = exp_q.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL wr2_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (rd !== e.data) begin errors++; $display("FAIL wr2_data_rd_held: got %h want %h", rd, e.data); end
        step();
        checks++; if (bif.mem_data_rd !== last_rd) begin errors++; $display("FAIL idle_data_rd_held: got %h want %h", bif.mem_data_rd, last_rd); end
    endtask

    task automatic test_back_to_back();
        int lat, rc; bit ok; logic [31:0] rd; logic flt; exp_t e;
        int r0, q0, d0;
        logic        t_wr[3]  = '{1'b0, 1'b1, 1'b0};
        int          t_wt[3]  = '{0, 0, 1};
        logic [31:0] t_dat[3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
        int          t_lat[3] = '{2, 2, 3};
        step();
        r0 = ready_cnt; q0 = req_cnt; d0 = dbl_cnt;
        for (int i = 0; i < 3; i++) begin
            if (!t_wr[i]) last_rd = t_dat[i];
            exp_q.push_back('{data: last_rd, fault: 1'b0, lat: t_lat[i]});
            do_txn(t_wr[i], 30'(32'h100 + i), t_dat[i], t_wt[i], 0, t_dat[i], 0, lat, rc, ok, rd, flt);
            e = exp_q.pop_front();
            checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (rd !== e.data) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd, e.data); end
        end
        step();
        step();
        checks++; if (ready_cnt - r0 != 3) begin errors++; $display("FAIL b2b_ready_count: got %0d want 3", ready_cnt - r0); end
        checks++; if (req_cnt - q0 != 3) begin errors++; $display("FAIL b2b_req_count: got %0d want 3", req_cnt - q0); end
        checks++; if (dbl_cnt != d0) begin errors++; $display("FAIL b2b_double_ready: got %0d want %0d", dbl_cnt, d0); end
    endtask

    task automatic test_start_in_wait();
        int lat, rc; bit ok; logic [31:0] rd; logic flt; exp_t e;
        int r0, q0;
        r0 = ready_cnt; q0 = req_cnt;
        last_rd = 32'h0F0F_7777;
        exp_q.push_back('{data: last_rd, fault: 1'b0, lat: 7});
        do_txn(1'b0, 30'h0000_0200, 32'h0, 0, 5, 32'h0F0F_7777, 3, lat, rc, ok, rd, flt);
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) step();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL poke_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (rd !== e.data) begin errors++; $display("FAIL poke_data: got %h want %h", rd, e.data); end
        checks++; if (req_cnt - q0 != 1) begin errors++; $display("FAIL poke_req_count: got %0d want 1", req_cnt - q0); end
        checks++; if (ready_cnt - r0 != 1) begin errors++; $display("FAIL poke_ready_count: got %0d want 1", ready_cnt - r0); end
    endtask

    task automatic test_stall();
        int lat, rc; bit ok; logic [31:0] rd; logic flt; exp_t e;
`ifdef CORE_MEM_TIMEOUT_EN
        // Stuck waitrequest: fault completion eight edges after the accepting edge.
        exp_q.push_back('{data: last_rd, fault: 1'b1, lat: 9});
        do_txn(1'b0, 30'h0000_0300, 32'h0, 100, 0, 32'h0, 0, lat, rc, ok, rd, flt);
        e = exp_q.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL to_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (flt !== e.fault) begin errors++; $display("FAIL to_fault: got %b want %b", flt, e.fault); end
        checks++; if (rd !== e.data) begin errors++; $display("FAIL to_data_held: got %h want %h", rd, e.data); end
        checks++; if (rc != 8) begin errors++; $display("FAIL to_req_cycles: got %0d want 8", rc); end
        checks++; if (bif.avl_read !== 1'b0) begin errors++; $display("FAIL to_req_dropped: got %b want 0", bif.avl_read); end
        last_rd = 32'h7E57_0001;
        exp_q.push_back('{data: last_rd, fault: 1'b0, lat: 2});
        do_txn(1'b0, 30'h0000_0301, 32'h0, 0, 0, 32'h7E57_0001, 0, lat, rc, ok, rd, flt);
        e = exp_q.pop_front();
        checks++; if (flt !== e.fault) begin errors++; $display("FAIL to_next_fault: got %b want %b", flt, e.fault); end
        checks++; if (rd !== e.data) begin errors++; $display("FAIL to_next_data: got %h want %h", rd, e.data); end
`else
        // Long stall: the bridge keeps waiting and never faults.
        last_rd = 32'hA5A5_0001;
        exp_q.push_back('{data: last_rd, fault: 1'b0, lat: 42});
        do_txn(1'b0, 30'h0000_0300, 32'h0, 40, 0, 32'hA5A5_0001, 0, lat, rc, ok, rd, flt);
        e = exp_q.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL stall_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (flt !== e.fault) begin errors++; $display("FAIL stall_fault: got %b want %b", flt, e.fault); end
        checks++; if (rc != 41) begin errors++; $display("FAIL stall_req_cycles: got %0d want 41", rc); end
        checks++; if (!ok) begin errors++; $display("FAIL stall_bus_fields: got unstable request want held"); end
        checks++; if (rd !== e.data) begin errors++; $display("FAIL stall_data: got %h want %h", rd, e.data); end
`endif
    endtask

    task automatic test_reset_mid();
        int r0;
        int lat, rc; bit ok; logic [31:0] rd; logic flt; exp_t e;
        bif.avl_waitrequest = 1'b1;
        bif.mem_start = 1'b1; bif.mem_write = 1'b0; bif.mem_addr = 30'h0AB;
        step();
        bif.mem_start = 1'b0; bif.mem_addr = '0;
        step();
        checks++; if (bif.avl_read !== 1'b1) begin errors++; $display("FAIL rm_read_pending: got %b want 1", bif.avl_read); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bif.avl_read !== 1'b0) begin errors++; $display("FAIL rm_async_drop: got %b want 0", bif.avl_read); end
        checks++; if (bif.avl_address !== 32'h0) begin errors++; $display("FAIL rm_addr_clear: got %h want 0", bif.avl_address); end
        bif.avl_waitrequest = 1'b0;
        step();
        rst_n = 1'b1;
        last_rd = 32'h0;
        r0 = ready_cnt;
        bif.avl_readdatavalid = 1'b1; bif.avl_readdata = 32'hCAFE_F00D;
        step();
        bif.avl_readdatavalid = 1'b0; bif.avl_readdata = '0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (ready_cnt != r0) begin errors++; $display("FAIL rm_stale_ready: got %0d pulses want 0", ready_cnt - r0); end
        checks++; if (bif.mem_data_rd !== last_rd) begin errors++; $display("FAIL rm_stale_data: got %h want %h", bif.mem_data_rd, last_rd); end
        // Bridge recovers cleanly after the reset.
        exp_q.push_back('{data: last_rd, fault: 1'b0, lat: 2});
        do_txn(1'b1, 30'h0000_0400, 32'h1357_9BDF, 0, 0, 32'h0, 0, lat, rc, ok, rd, flt);
        e = exp_q.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL rm_recover_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (!ok) begin errors++; $display("FAIL rm_recover_fields: got bad request want addr 00001000"); end
    endtask

    initial begin
        checks = 0; errors = 0;
        ready_cnt = 0; req_cnt = 0; dbl_cnt = 0;
        prev_ready = 1'b0; prev_req = 1'b0;
        last_rd = 32'h0;
        rst_n = 1'b0;
        bif.mem_start = 1'b0; bif.mem_write = 1'b0; bif.mem_addr = '0; bif.mem_data_wr = '0;
        bif.avl_waitrequest = 1'b0; bif.avl_readdata = '0; bif.avl_readdatavalid = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_start_in_wait();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
